// File: rtl/cordic_polar_iter.sv
// Iterative CORDIC vectoring engine: signed (x, y) -> magnitude and binary-angle phase.
// Optional gain compensation stage enabled by defining CORDIC_GAIN_COMP_EN.
module cordic_polar_iter #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned ITER    = 8,
    parameter int unsigned ANGLE_W = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      ena,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [WIDTH-1:0]   x_in,
    input  logic signed [WIDTH-1:0]   y_in,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH+1:0]          mag_out,
    output logic [ANGLE_W-1:0]        ang_out,
    output logic                      busy
);

    localparam int unsigned DW    = WIDTH + 2;
    localparam int unsigned CNT_W = (ITER > 1) ? $clog2(ITER) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ROT  = 2'd1,
        S_COMP = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                   state_q, state_d;
    logic signed [DW-1:0]     x_q, x_d, y_q, y_d;
    logic signed [DW-1:0]     x_ext, y_ext, x_sh, y_sh;
    logic [ANGLE_W-1:0]       z_q, z_d, a_i;
    logic [CNT_W-1:0]         i_q, i_d;
    logic                     zero_q, zero_d;
    logic [DW-1:0]            mag_d;
    logic [ANGLE_W-1:0]       ang_d;
    logic                     ov_d, busy_d;
`ifdef CORDIC_GAIN_COMP_EN
    logic signed [DW-1:0]     x_comp;
`endif

    // Arctangent table, 16-bit full-circle units scaled down to ANGLE_W bits
    function automatic logic [ANGLE_W-1:0] atan_lut(input int unsigned idx);
        logic [15:0] a;
        case (idx)
            0:       a = 16'd8192;
            1:       a = 16'd4836;
            2:       a = 16'd2555;
            3:       a = 16'd1297;
            4:       a = 16'd651;
            5:       a = 16'd326;
            6:       a = 16'd163;
            7:       a = 16'd81;
            8:       a = 16'd41;
            9:       a = 16'd20;
            10:      a = 16'd10;
            11:      a = 16'd5;
            12:      a = 16'd3;
            13:      a = 16'd1;
            14:      a = 16'd1;
            default: a = 16'd0;
        endcase
        return ANGLE_W'(a >> (16 - ANGLE_W));
    endfunction

    assign in_ready = rst_n & ena & (state_q == S_IDLE);

    // Next-state, datapath and output computation
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        i_d     = i_q;
        zero_d  = zero_q;
        mag_d   = mag_out;
        ang_d   = ang_out;
        ov_d    = out_valid;
        x_ext   = DW'(x_in);
        y_ext   = DW'(y_in);
        x_sh    = x_q >>> i_q;
        y_sh    = y_q >>> i_q;
        a_i     = atan_lut(32'(i_q));
`ifdef CORDIC_GAIN_COMP_EN
        // 1/K ~= 2^-1 + 2^-3 - 2^-6 - 2^-9, truncating shifts
        x_comp  = (x_q >>> 1) + (x_q >>> 3) - (x_q >>> 6) - (x_q >>> 9);
`endif
        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready) begin
                    // Fold left half-plane onto the right so the rotations converge
                    if (x_in[WIDTH-1]) begin
                        x_d = -x_ext;
                        y_d = -y_ext;
                        z_d = {1'b1, {(ANGLE_W-1){1'b0}}};
                    end else begin
                        x_d = x_ext;
                        y_d = y_ext;
                        z_d = '0;
                    end
                    zero_d  = (x_in == '0) && (y_in == '0);
                    i_d     = '0;
                    state_d = S_ROT;
                end
            end
            S_ROT: begin
                if (!y_q[DW-1]) begin
                    x_d = x_q + y_sh;
                    y_d = y_q - x_sh;
                    z_d = z_q + a_i;
                end else begin
                    x_d = x_q - y_sh;
                    y_d = y_q + x_sh;
                    z_d = z_q - a_i;
                end
                if (i_q == CNT_W'(ITER - 1)) begin
                    i_d = '0;
`ifdef CORDIC_GAIN_COMP_EN
                    state_d = S_COMP;
`else
                    state_d = S_DONE;
`endif
                end else begin
                    i_d = i_q + CNT_W'(1);
                end
            end
`ifdef CORDIC_GAIN_COMP_EN
            S_COMP: begin
                x_d     = x_comp;
                state_d = S_DONE;
            end
`endif
            S_DONE: begin
                // Load result once, then hold it until the consumer takes it
                if (!out_valid) begin
                    mag_d = x_q;
                    ang_d = zero_q ? '0 : z_q;
                    ov_d  = 1'b1;
                end else if (out_ready) begin
                    ov_d    = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and datapath registers; ena low freezes everything
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            x_q       <= '0;
            y_q       <= '0;
            z_q       <= '0;
            i_q       <= '0;
            zero_q    <= 1'b0;
            mag_out   <= '0;
            ang_out   <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else if (ena) begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            z_q       <= z_d;
            i_q       <= i_d;
            zero_q    <= zero_d;
            mag_out   <= mag_d;
            ang_out   <= ang_d;
            out_valid <= ov_d;
            busy      <= busy_d;
        end
    end

endmodule

// File: tb/tb_cordic_polar_iter.sv
// Self-checking bench for cordic_polar_iter (honours CORDIC_GAIN_COMP_EN when defined).
module tb_cordic_polar_iter;

    localparam int WIDTH   = 8;
    localparam int ITER    = 8;
    localparam int ANGLE_W = 8;
    localparam int DW      = WIDTH + 2;
    localparam int FULL    = 1 << ANGLE_W;
`ifdef CORDIC_GAIN_COMP_EN
    localparam int LAT     = ITER + 2;
`else
    localparam int LAT     = ITER + 1;
`endif
    localparam real PI     = 3.14159265358979;

    logic                     clk;
    logic                     rst_n;
    logic                     ena;
    logic                     in_valid;
    logic                     in_ready;
    logic signed [WIDTH-1:0]  x_in;
    logic signed [WIDTH-1:0]  y_in;
    logic                     out_valid;
    logic                     out_ready;
    logic [DW-1:0]            mag_out;
    logic [ANGLE_W-1:0]       ang_out;
    logic                     busy;

    int n_checks = 0;
    int n_fail   = 0;
    int atan16[16] = '{8192, 4836, 2555, 1297, 651, 326, 163, 81, 41, 20, 10, 5, 3, 1, 1, 0};
    real kgain;

    cordic_polar_iter #(.WIDTH(WIDTH), .ITER(ITER), .ANGLE_W(ANGLE_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_in      (x_in),
        .y_in      (y_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .mag_out   (mag_out),
        .ang_out   (ang_out),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: vectoring CORDIC on plain integers, straight from the algorithm definition
    task automatic model(input int xi, input int yi, output int mag, output int ang);
        int x, y, z, xn, yn, a;
        if (xi < 0) begin x = -xi; y = -yi; z = FULL / 2; end
        else        begin x = xi;  y = yi;  z = 0;        end
        for (int k = 0; k < ITER; k++) begin
            a = atan16[k] >> (16 - ANGLE_W);
            if (y >= 0) begin xn = x + (y >>> k); yn = y - (x >>> k); z = z + a; end
            else        begin xn = x - (y >>> k); yn = y + (x >>> k); z = z - a; end
            x = xn;
            y = yn;
            z = z & (FULL - 1);
        end
`ifdef CORDIC_GAIN_COMP_EN
        x = (x >>> 1) + (x >>> 3) - (x >>> 6) - (x >>> 9);
`endif
        mag = x;
        ang = (xi == 0 && yi == 0) ? 0 : z;
    endtask

    // Ideal polar values for loose sanity checks
    task automatic ideal(input int xi, input int yi, output real mag, output real ang);
        mag = $sqrt(real'(xi * xi + yi * yi));
`ifndef CORDIC_GAIN_COMP_EN
        mag = mag * kgain;
`endif
        ang = $atan2(real'(yi), real'(xi)) / (2.0 * PI) * real'(FULL);
        if (ang < 0.0) ang = ang + real'(FULL);
    endtask

    // Accept one operand pair, wait (bounded) for the result; lat=-1 on timeout
    task automatic run_conv(input int xi, input int yi, output int mag, output int ang,
                            output int lat, output logic rdy_at_accept);
        int k;
        x_in = WIDTH'(xi);
        y_in = WIDTH'(yi);
        rdy_at_accept = in_ready;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        k = 0;
        while (!out_valid && k < LAT + 20) begin
            step();
            k++;
        end
        lat = out_valid ? k : -1;
        mag = int'(mag_out);
        ang = int'(ang_out);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ena = 1'b1; in_valid = 1'b0; out_ready = 1'b0; x_in = '0; y_in = '0;
        #3;
        n_checks++;
        if ({out_valid, busy, in_ready} !== 3'b000 || mag_out !== '0 || ang_out !== '0) begin
            n_fail++;
            $display("FAIL reset_hold: ov=%b busy=%b rdy=%b mag=%0d ang=%0d, want all 0",
                     out_valid, busy, in_ready, mag_out, ang_out);
        end
        step();
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ready: in_ready=%b, want 1", in_ready);
        end
        step();
        n_checks++;
        if ({out_valid, busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_idle: ov=%b busy=%b, want 0 0", out_valid, busy);
        end
    endtask

    task automatic test_named();
        int xs[6] = '{30, -15, 30, -128, 0, 0};
        int ys[6] = '{40, 20, -25, 0, 0, -128};
        int mag, ang, lat, em, ea;
        real im, ia, da;
        logic rdy;
        for (int t = 0; t < 6; t++) begin
            run_conv(xs[t], ys[t], mag, ang, lat, rdy);
            model(xs[t], ys[t], em, ea);
            ideal(xs[t], ys[t], im, ia);
            n_checks++;
            if (rdy !== 1'b1) begin
                n_fail++;
                $display("FAIL named_ready[%0d]: in_ready=%b, want 1", t, rdy);
            end
            n_checks++;
            if (lat != LAT) begin
                n_fail++;
                $display("FAIL named_latency[%0d]: got %0d cycles, want %0d", t, lat, LAT);
            end
            n_checks++;
            if (mag != em || ang != ea) begin
                n_fail++;
                $display("FAIL named_result[%0d] (%0d,%0d): mag=%0d ang=%0d, want mag=%0d ang=%0d",
                         t, xs[t], ys[t], mag, ang, em, ea);
            end
            // Shift truncation biases the integer result by a few LSBs vs. ideal
            da = (real'(ang) > ia) ? real'(ang) - ia : ia - real'(ang);
            if (da > real'(FULL) / 2.0) da = real'(FULL) - da;
            n_checks++;
            if ((real'(mag) - im > 4.0) || (im - real'(mag) > 4.0) ||
                (!(xs[t] == 0 && ys[t] == 0) && da > 3.0)) begin
                n_fail++;
                $display("FAIL named_ideal[%0d]: mag=%0d ang=%0d, want about %0.2f / %0.2f",
                         t, mag, ang, im, ia);
            end
        end
        // Explicit boundary values
        run_conv(0, 0, mag, ang, lat, rdy);
        n_checks++;
        if (mag != 0 || ang != 0) begin
            n_fail++;
            $display("FAIL zero_vector: mag=%0d ang=%0d, want 0 0", mag, ang);
        end
        run_conv(-128, 0, mag, ang, lat, rdy);
        n_checks++;
        if (ang < FULL / 2 - 1 || ang > FULL / 2 + 1) begin
            n_fail++;
            $display("FAIL neg_full_scale_angle: ang=%0d, want %0d +/-1", ang, FULL / 2);
        end
    endtask

    task automatic test_random();
        int xi, yi, mag, ang, lat, em, ea;
        logic rdy;
        for (int t = 0; t < 60; t++) begin
            xi = int'($urandom_range(0, (1 << WIDTH) - 1)) - (1 << (WIDTH - 1));
            yi = int'($urandom_range(0, (1 << WIDTH) - 1)) - (1 << (WIDTH - 1));
            run_conv(xi, yi, mag, ang, lat, rdy);
            model(xi, yi, em, ea);
            n_checks++;
            if (lat != LAT || mag != em || ang != ea) begin
                n_fail++;
                $display("FAIL random[%0d] (%0d,%0d): lat=%0d mag=%0d ang=%0d, want lat=%0d mag=%0d ang=%0d",
                         t, xi, yi, lat, mag, ang, LAT, em, ea);
            end
        end
    endtask

    task automatic test_backpressure();
        int k, mag0, ang0, em, ea;
        logic bad;
        model(30, 40, em, ea);
        x_in = 8'sd30; y_in = 8'sd40; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        k = 0;
        while (!out_valid && k < LAT + 20) begin step(); k++; end
        mag0 = int'(mag_out);
        ang0 = int'(ang_out);
        n_checks++;
        if (!out_valid || mag0 != em || ang0 != ea) begin
            n_fail++;
            $display("FAIL bp_result: ov=%b mag=%0d ang=%0d, want 1 %0d %0d", out_valid, mag0, ang0, em, ea);
        end
        bad = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (c == 2) begin x_in = -8'sd15; y_in = 8'sd20; in_valid = 1'b1; end
            step();
            in_valid = 1'b0;
            if (!out_valid || in_ready || !busy || int'(mag_out) != mag0 || int'(ang_out) != ang0)
                bad = 1'b1;
        end
        n_checks++;
        if (bad) begin
            n_fail++;
            $display("FAIL bp_hold: ov=%b rdy=%b mag=%0d ang=%0d, want held 1 0 %0d %0d",
                     out_valid, in_ready, mag_out, ang_out, mag0, ang0);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        n_checks++;
        if ({out_valid, busy, in_ready} !== 3'b001) begin
            n_fail++;
            $display("FAIL bp_handshake: ov=%b busy=%b rdy=%b, want 0 0 1", out_valid, busy, in_ready);
        end
        bad = 1'b0;
        for (int c = 0; c < LAT + 3; c++) begin
            step();
            if (out_valid || busy) bad = 1'b1;
        end
        n_checks++;
        if (bad) begin
            n_fail++;
            $display("FAIL bp_ignored_input: ov=%b busy=%b, want 0 0", out_valid, busy);
        end
        // Consumer ready before the result exists: result still appears on time
        out_ready = 1'b1;
        x_in = 8'sd30; y_in = -8'sd25; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        k = 0;
        while (!out_valid && k < LAT + 20) begin step(); k++; end
        model(30, -25, em, ea);
        n_checks++;
        if (k != LAT || int'(mag_out) != em || int'(ang_out) != ea) begin
            n_fail++;
            $display("FAIL early_ready: lat=%0d mag=%0d ang=%0d, want %0d %0d %0d",
                     k, mag_out, ang_out, LAT, em, ea);
        end
        step();
        out_ready = 1'b0;
        n_checks++;
        if ({out_valid, busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL early_ready_release: ov=%b busy=%b, want 0 0", out_valid, busy);
        end
        // Back-to-back: accept on the very next cycle after the handshake
        x_in = -8'sd15; y_in = 8'sd20; in_valid = 1'b1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL back_to_back_ready: in_ready=%b, want 1", in_ready);
        end
        step();
        in_valid = 1'b0;
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL back_to_back_accept: busy=%b, want 1", busy);
        end
        k = 0;
        while (!out_valid && k < LAT + 20) begin step(); k++; end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_ena_stall();
        int k, em, ea;
        logic bad;
        // ena low in IDLE blocks acceptance
        ena = 1'b0;
        x_in = 8'sd30; y_in = 8'sd40; in_valid = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL ena_idle_ready: in_ready=%b, want 0", in_ready);
        end
        step();
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL ena_idle_accept: busy=%b, want 0", busy);
        end
        ena = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        ena = 1'b0;
        out_ready = 1'b1;
        bad = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            if (!busy || in_ready || out_valid) bad = 1'b1;
        end
        out_ready = 1'b0;
        ena = 1'b1;
        n_checks++;
        if (bad) begin
            n_fail++;
            $display("FAIL ena_stall_freeze: busy=%b rdy=%b ov=%b, want 1 0 0", busy, in_ready, out_valid);
        end
        k = 5;
        while (!out_valid && k < LAT + 30) begin step(); k++; end
        model(30, 40, em, ea);
        n_checks++;
        if (k != LAT + 3 || int'(mag_out) != em || int'(ang_out) != ea) begin
            n_fail++;
            $display("FAIL ena_stall_result: lat=%0d mag=%0d ang=%0d, want %0d %0d %0d",
                     k, mag_out, ang_out, LAT + 3, em, ea);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_rot();
        logic seen;
        x_in = 8'sd30; y_in = 8'sd40; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        step();
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({out_valid, busy, in_ready} !== 3'b000 || mag_out !== '0 || ang_out !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_rot: ov=%b busy=%b rdy=%b mag=%0d ang=%0d, want all 0",
                     out_valid, busy, in_ready, mag_out, ang_out);
        end
        #1;
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_rot_ready: in_ready=%b, want 1", in_ready);
        end
        seen = 1'b0;
        for (int c = 0; c < LAT + 5; c++) begin
            step();
            if (out_valid || busy) seen = 1'b1;
        end
        n_checks++;
        if (seen) begin
            n_fail++;
            $display("FAIL reset_mid_rot_spurious: ov=%b busy=%b, want 0 0", out_valid, busy);
        end
    endtask

    initial begin
        kgain = 1.0;
        for (int k = 0; k < ITER; k++) kgain = kgain * $sqrt(1.0 + 1.0 / (4.0 ** k));
        test_reset();
        test_named();
        test_random();
        test_backpressure();
        test_ena_stall();
        test_reset_mid_rot();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
